// File: rtl/perm_run_pkg.sv
// rtl/perm_run_pkg.sv - shared state encoding and switch widths for the permitted-run controller
//
// Purpose : state encoding and switch-bank widths shared by perm_run_controller.
// Ports   : none (package).

package perm_run_pkg;

   localparam int ACT_W = 3;   // actuator request switches {D,E,F}
   localparam int SEL_W = 3;   // selector switches {A,B,C}

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_DENY = 2'd3
   } run_state_t;

endpackage

// File: rtl/perm_run_controller_rise_detect.sv
// rtl/perm_run_controller_rise_detect.sv - single-flop rising-edge detector
//
// Purpose : flags the cycle in which d is high and was low on the previous edge.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset, clears the history flop
//           d    - level input, already synchronised
//           rise - combinational d & ~d_q

module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/perm_run_controller.sv
// rtl/perm_run_controller.sv - timed actuator run controller gated by the live permit flag
//
// Purpose : on a start press, latches a permitted actuator request and drives it for
//           RUN_CYCLES cycles; a refused request or a permit lost mid-run raises a timed
//           alarm and bumps a saturating refusal counter.
// Ports   : clk, rst     - clock and synchronous active-high reset
//           sel_in       - selector switches {A,B,C}
//           act_in       - actuator request switches {D,E,F}
//           perm_in      - live permit flag from the permission checker
//           start, stop  - operator controls (levels)
//           act_out      - latched actuator drive
//           mode_out     - selector latched for the current/last run
//           busy, done   - running flag, one-cycle completion pulse
//           alarm        - refusal/fault indication
//           deny_count   - saturating refusal/fault count

module perm_run_controller
   import perm_run_pkg::*;
#(
   parameter int RUN_CYCLES   = 1000,
   parameter int ALARM_CYCLES = 250,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel_in,
   input  logic [ACT_W-1:0] act_in,
   input  logic             perm_in,
   input  logic             start,
   input  logic             stop,
   output logic [ACT_W-1:0] act_out,
   output logic [SEL_W-1:0] mode_out,
   output logic             busy,
   output logic             done,
   output logic             alarm,
   output logic [CNT_W-1:0] deny_count
);

   // Timer only has to hold the larger load value; kept at least one bit wide.
   localparam int MAX_CYC = (RUN_CYCLES > ALARM_CYCLES) ? RUN_CYCLES : ALARM_CYCLES;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TMR_W-1:0] RUN_LOAD   = TMR_W'(RUN_CYCLES - 1);
   localparam logic [TMR_W-1:0] ALARM_LOAD = TMR_W'(ALARM_CYCLES - 1);

   run_state_t       state, state_n;
   logic [TMR_W-1:0] timer, timer_n;
   logic [ACT_W-1:0] act_n;
   logic [SEL_W-1:0] mode_n;
   logic             cnt_inc;
   logic             start_rise;

   rise_detect u_start_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (start),
      .rise (start_rise)
   );

   always_comb begin
      state_n = state;
      timer_n = timer;
      act_n   = act_out;
      mode_n  = mode_out;
      cnt_inc = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start_rise) begin
               if (perm_in && (act_in != '0)) begin
                  state_n = ST_RUN;
                  timer_n = RUN_LOAD;
                  act_n   = act_in;
                  mode_n  = sel_in;
               end else begin
                  state_n = ST_DENY;
                  timer_n = ALARM_LOAD;
                  cnt_inc = 1'b1;
               end
            end
         end

         ST_RUN: begin
            // Stop outranks both a permit fault and normal expiry, so an operator
            // stop on the final cycle never produces a done pulse.
            if (stop) begin
               state_n = ST_IDLE;
               act_n   = '0;
            end else if (!perm_in) begin
               state_n = ST_DENY;
               timer_n = ALARM_LOAD;
               act_n   = '0;
               cnt_inc = 1'b1;
            end else if (timer == '0) begin
               state_n = ST_DONE;
               act_n   = '0;
            end else begin
               timer_n = timer - 1'b1;
            end
         end

         ST_DONE: begin
            state_n = ST_IDLE;
         end

         ST_DENY: begin
            if (stop || (timer == '0)) begin
               state_n = ST_IDLE;
            end else begin
               timer_n = timer - 1'b1;
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they move on the same
   // edge as the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         timer      <= '0;
         act_out    <= '0;
         mode_out   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         alarm      <= 1'b0;
         deny_count <= '0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         act_out  <= act_n;
         mode_out <= mode_n;
         busy     <= (state_n == ST_RUN);
         done     <= (state_n == ST_DONE);
         alarm    <= (state_n == ST_DENY);
         if (cnt_inc && (deny_count != '1)) begin
            deny_count <= deny_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_perm_run_controller.sv
// tb/tb_perm_run_controller.sv - self-checking bench for perm_run_controller

module tb_perm_run_controller;

   localparam int RUN_C   = 8;
   localparam int ALARM_C = 4;
   localparam int CW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] sel_in;
   logic [2:0] act_in;
   logic       perm_in;
   logic       start;
   logic       stop;
   logic [2:0] act_out;
   logic [2:0] mode_out;
   logic       busy;
   logic       done;
   logic       alarm;
   logic [CW-1:0] deny_count;

   int checks   = 0;
   int failures = 0;

   // tallies of DUT activity, cleared at the start of each directed scenario
   int busy_n;
   int done_n;
   int alarm_n;

   // reference model: phase name plus cycles still to go in that phase
   string      m_phase;
   int         m_left;
   bit         m_start_prev;
   logic [2:0] m_act;
   logic [2:0] m_mode;
   int         m_cnt;

   always #5 clk = ~clk;

   perm_run_controller #(
      .RUN_CYCLES   (RUN_C),
      .ALARM_CYCLES (ALARM_C),
      .CNT_W        (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sel_in     (sel_in),
      .act_in     (act_in),
      .perm_in    (perm_in),
      .start      (start),
      .stop       (stop),
      .act_out    (act_out),
      .mode_out   (mode_out),
      .busy       (busy),
      .done       (done),
      .alarm      (alarm),
      .deny_count (deny_count)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase      = "IDLE";
      m_left       = 0;
      m_start_prev = 1'b0;
      m_act        = '0;
      m_mode       = '0;
      m_cnt        = 0;
   endtask

   task automatic model_refuse();
      m_phase = "DENY";
      m_left  = ALARM_C;
      if (m_cnt < CNT_MAX) m_cnt++;
   endtask

   // advances the model by one clock edge using the inputs held at that edge
   task automatic model_edge();
      bit pressed;
      if (rst) begin
         model_reset();
         return;
      end
      pressed      = start && !m_start_prev;
      m_start_prev = start;
      if (m_phase == "IDLE") begin
         if (pressed) begin
            if (perm_in && act_in != 3'b000) begin
               m_phase = "RUN";
               m_left  = RUN_C;
               m_act   = act_in;
               m_mode  = sel_in;
            end else begin
               model_refuse();
            end
         end
      end else if (m_phase == "RUN") begin
         if (stop) begin
            m_phase = "IDLE";
            m_act   = '0;
         end else if (!perm_in) begin
            m_act = '0;
            model_refuse();
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_phase = "DONE";
               m_act   = '0;
            end
         end
      end else if (m_phase == "DONE") begin
         m_phase = "IDLE";
      end else begin
         if (stop) begin
            m_phase = "IDLE";
         end else begin
            m_left--;
            if (m_left == 0) m_phase = "IDLE";
         end
      end
   endtask

   task automatic step(input logic r, input logic st, input logic sp, input logic p,
                       input logic [2:0] s, input logic [2:0] a);
      rst     = r;
      start   = st;
      stop    = sp;
      perm_in = p;
      sel_in  = s;
      act_in  = a;
      @(posedge clk);
      model_edge();
      #1;
      check("act_out",    {5'd0, act_out},  {5'd0, m_act});
      check("mode_out",   {5'd0, mode_out}, {5'd0, m_mode});
      check("busy",       {7'd0, busy},     {7'd0, (m_phase == "RUN")});
      check("done",       {7'd0, done},     {7'd0, (m_phase == "DONE")});
      check("alarm",      {7'd0, alarm},    {7'd0, (m_phase == "DENY")});
      check("deny_count", 8'(deny_count),   8'(m_cnt));
      if (busy)  busy_n++;
      if (done)  done_n++;
      if (alarm) alarm_n++;
   endtask

   task automatic idle_steps(input int n, input logic p);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, p, 3'b101, 3'b001);
   endtask

   task automatic clear_tallies();
      busy_n  = 0;
      done_n  = 0;
      alarm_n = 0;
   endtask

   initial begin
      model_reset();
      clear_tallies();

      // reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
      idle_steps(2, 1'b1);

      // permitted run
      clear_tallies();
      step(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 3'b001);
      check("run_mode_latched", {5'd0, mode_out}, 8'h05);
      idle_steps(12, 1'b1);
      check("run_busy_cycles", 8'(busy_n), 8'(RUN_C));
      check("run_done_pulses", 8'(done_n), 8'd1);
      check("run_no_count", 8'(deny_count), 8'd0);

      // refusal
      clear_tallies();
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b100);
      idle_steps(6, 1'b0);
      check("refuse_alarm_cycles", 8'(alarm_n), 8'(ALARM_C));
      check("refuse_count", 8'(deny_count), 8'd1);

      // mid-run permit loss
      clear_tallies();
      step(1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 3'b110);
      idle_steps(2, 1'b1);
      idle_steps(7, 1'b0);
      check("fault_alarm_cycles", 8'(alarm_n), 8'(ALARM_C));
      check("fault_no_done", 8'(done_n), 8'd0);
      check("fault_count", 8'(deny_count), 8'd2);

      // stop on the final run cycle beats expiry
      clear_tallies();
      step(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 3'b010);
      idle_steps(RUN_C - 1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 3'b010);
      idle_steps(3, 1'b1);
      check("stop_busy_cycles", 8'(busy_n), 8'(RUN_C));
      check("stop_no_done", 8'(done_n), 8'd0);

      // stop acknowledges an alarm on the next edge
      clear_tallies();
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b010);
      step(1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b010);
      idle_steps(3, 1'b0);
      check("ack_alarm_cycles", 8'(alarm_n), 8'd1);

      // start held high: a single run only
      clear_tallies();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 3'b111);
      idle_steps(3, 1'b1);
      check("held_busy_cycles", 8'(busy_n), 8'(RUN_C));
      check("held_done_pulses", 8'(done_n), 8'd1);

      // saturation after repeated refusals
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
         step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001);
      end
      check("sat_count", 8'(deny_count), 8'(CNT_MAX));

      // reset mid-run
      step(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b011);
      idle_steps(3, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 3'b011);
      check("rst_act_out", {5'd0, act_out}, 8'd0);
      check("rst_mode_out", {5'd0, mode_out}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_count", 8'(deny_count), 8'd0);
      idle_steps(2, 1'b1);

      // randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) != 0),
              3'($urandom),
              ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
